carrier_burst_sequencer: RTL and testbench

CARRIER_BURST_SEQUENCER -- requirements
Module: carrier_burst_sequencer

---
 rtl/carrier_burst_sequencer.sv | 218 +++++++++++++++++++++
 tb/tb_carrier_burst_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/carrier_burst_sequencer.sv
// ---------------------------------------------------------------------------
// carrier_burst_sequencer
//
// Sequences one modified-Miller style carrier burst for a sine generator.
// A burst is: GUARD_CLKS of plain carrier, then len bits of BIT_CLKS each,
// where every bit contains one carrier-off pause of PAUSE_CLKS, then another
// GUARD_CLKS of plain carrier and a single DONE cycle. A '0' bit pauses at
// the start of the bit and a '1' bit pauses at mid-bit. The phase-step strobe
// keeps running through pauses so the generated sine stays phase-continuous.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_in          asynchronous active-low reset
//   start_in        request a burst (only looked at in IDLE)
//   abort_in        kill any burst, back to IDLE on the next cycle
//   data_in[63:0]   frame bits, sent LSB first
//   len_in[6:0]     bit count 0..64, larger values clamp to 64
//   step_out        phase-step strobe, one pulse every STEP_DIV active cycles
//   carrier_en_out  1 = carrier on, 0 = carrier gated off
//   busy_out        high from the first LEAD cycle through the last TRAIL cycle
//   done_out        one-cycle pulse in DONE
//   bit_idx_out     index of the bit being sent, 0 outside DATA
// ---------------------------------------------------------------------------
module carrier_burst_sequencer #(
  parameter int BIT_CLKS   = 1391,
  parameter int PAUSE_CLKS = 347,
  parameter int GUARD_CLKS = 1024,
  parameter int STEP_DIV   = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        abort_in,
  input  logic [63:0] data_in,
  input  logic [6:0]  len_in,
  output logic        step_out,
  output logic        carrier_en_out,
  output logic        busy_out,
  output logic        done_out,
  output logic [6:0]  bit_idx_out
);

  localparam int CNT_MAX = (GUARD_CLKS > BIT_CLKS) ? GUARD_CLKS : BIT_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int STEP_W  = $clog2(STEP_DIV + 1);

  localparam logic [CNT_W-1:0]  GUARD_LAST   = CNT_W'(GUARD_CLKS - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0]  HALF_BIT     = CNT_W'(BIT_CLKS / 2);
  localparam logic [CNT_W-1:0]  ZERO_PAUSE_END = CNT_W'(PAUSE_CLKS);
  localparam logic [CNT_W-1:0]  ONE_PAUSE_END  = CNT_W'(BIT_CLKS / 2 + PAUSE_CLKS);
  localparam logic [STEP_W-1:0] STEP_LAST    = STEP_W'(STEP_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_DATA,
    ST_TRAIL,
    ST_DONE
  } state_t;

  state_t              state, next_state;
  logic [CNT_W-1:0]    cnt, next_cnt;
  logic [6:0]          bit_idx, next_bit_idx;
  logic [STEP_W-1:0]   step_cnt, next_step_cnt;
  logic [63:0]         data_q;
  logic [6:0]          len_q;
  logic                latch;
  logic                next_active;
  logic                next_step;
  logic                next_carrier;
  logic                next_busy;
  logic                next_done;
  logic [6:0]          next_bit_out;
  logic                cur_bit;

  // Next-state and counter logic. cnt is the in-state cycle counter for
  // LEAD/TRAIL and the cycle-in-bit counter in DATA. Abort is applied last
  // so it overrides whatever the state itself wanted to do.
  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    next_bit_idx  = bit_idx;
    latch         = 1'b0;

    case (state)
      ST_IDLE: begin
        next_cnt     = '0;
        next_bit_idx = '0;
        if (start_in) begin
          next_state = ST_LEAD;
          latch      = 1'b1;
        end
      end
      ST_LEAD: begin
        if (cnt == GUARD_LAST) begin
          next_cnt   = '0;
          next_state = (len_q == 7'd0) ? ST_TRAIL : ST_DATA;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          next_cnt = '0;
          if (bit_idx == len_q - 7'd1) begin
            next_state   = ST_TRAIL;
            next_bit_idx = '0;
          end else begin
            next_bit_idx = bit_idx + 7'd1;
          end
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      ST_TRAIL: begin
        if (cnt == GUARD_LAST) begin
          next_cnt   = '0;
          next_state = ST_DONE;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end
      ST_DONE: begin
        next_cnt   = '0;
        next_state = ST_IDLE;
      end
      default: begin
        next_cnt     = '0;
        next_bit_idx = '0;
        next_state   = ST_IDLE;
      end
    endcase

    if (abort_in) begin
      next_state   = ST_IDLE;
      next_cnt     = '0;
      next_bit_idx = '0;
      latch        = 1'b0;
    end
  end

  // Output decode from the upcoming state so every output can be a plain
  // register that lines up with the state it describes. The step divider
  // restarts at zero on entry to LEAD so the first pulse lands on the first
  // LEAD cycle, then free-runs across LEAD, DATA and TRAIL.
  always_comb begin
    next_active   = (next_state == ST_LEAD) || (next_state == ST_DATA) ||
                    (next_state == ST_TRAIL);
    next_step_cnt = '0;
    next_step     = 1'b0;
    next_carrier  = 1'b0;
    next_busy     = next_active;
    next_done     = (next_state == ST_DONE);
    next_bit_out  = '0;
    cur_bit       = data_q[next_bit_idx[5:0]];

    if (next_active && (state != ST_IDLE)) begin
      next_step_cnt = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end
    if (next_active) begin
      next_step = (next_step_cnt == '0);
    end

    case (next_state)
      ST_LEAD, ST_TRAIL: next_carrier = 1'b1;
      ST_DATA: begin
        next_bit_out = next_bit_idx;
        if (cur_bit) begin
          next_carrier = !((next_cnt >= HALF_BIT) && (next_cnt < ONE_PAUSE_END));
        end else begin
          next_carrier = (next_cnt >= ZERO_PAUSE_END);
        end
      end
      default: next_carrier = 1'b0;
    endcase
  end

  // State, counters and the latched frame. The frame is only captured on
  // start acceptance, so inputs changing mid-burst cannot disturb it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      step_cnt <= '0;
      data_q   <= '0;
      len_q    <= '0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      bit_idx  <= next_bit_idx;
      step_cnt <= next_step_cnt;
      if (latch) begin
        data_q <= data_in;
        len_q  <= (len_in > 7'd64) ? 7'd64 : len_in;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      step_out       <= 1'b0;
      carrier_en_out <= 1'b0;
      busy_out       <= 1'b0;
      done_out       <= 1'b0;
      bit_idx_out    <= '0;
    end else begin
      step_out       <= next_step;
      carrier_en_out <= next_carrier;
      busy_out       <= next_busy;
      done_out       <= next_done;
      bit_idx_out    <= next_bit_out;
    end
  end

endmodule

// File: tb/tb_carrier_burst_sequencer.sv
// ---------------------------------------------------------------------------
// tb_carrier_burst_sequencer
//
// Directed bench for carrier_burst_sequencer with small parameters
// (BIT_CLKS=16, PAUSE_CLKS=4, GUARD_CLKS=8, STEP_DIV=2). Outputs are packed
// as {step, carrier, busy, done, bit_idx} and compared cycle by cycle
// against a burst timeline worked out from the burst definition.
// ---------------------------------------------------------------------------
module tb_carrier_burst_sequencer;

  localparam int BIT   = 16;
  localparam int PAUSE = 4;
  localparam int GUARD = 8;
  localparam int SDIV  = 2;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b1;
  logic        start_in = 1'b0;
  logic        abort_in = 1'b0;
  logic [63:0] data_in  = '0;
  logic [6:0]  len_in   = '0;
  logic        step_out;
  logic        carrier_en_out;
  logic        busy_out;
  logic        done_out;
  logic [6:0]  bit_idx_out;

  int compared   = 0;
  int mismatched = 0;

  int busyC, offC, stepC, pauseC, stepInPause;

  localparam logic [10:0] IDLE_VEC  = 11'b0;
  localparam logic [10:0] LEAD0_VEC = {1'b1, 1'b1, 1'b1, 1'b0, 7'd0};

  carrier_burst_sequencer #(
    .BIT_CLKS  (BIT),
    .PAUSE_CLKS(PAUSE),
    .GUARD_CLKS(GUARD),
    .STEP_DIV  (SDIV)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .abort_in      (abort_in),
    .data_in       (data_in),
    .len_in        (len_in),
    .step_out      (step_out),
    .carrier_en_out(carrier_en_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .bit_idx_out   (bit_idx_out)
  );

  // Free-running 10-unit clock.
  always #5 clk_in = ~clk_in;

  // Advance to just after the next rising edge so outputs are settled.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a,
                               input logic [63:0] d, input logic [6:0] l);
    start_in = s;
    abort_in = a;
    data_in  = d;
    len_in   = l;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outVec();
    return {step_out, carrier_en_out, busy_out, done_out, bit_idx_out};
  endfunction

  // Expected outputs t cycles after the accepting edge of a burst of l bits.
  function automatic logic [10:0] expectedVec(input int t, input logic [63:0] d,
                                              input int l);
    int dataEnd, trailEnd, k, c;
    logic st, ce, bz, dn;
    logic [6:0] idx;
    dataEnd  = GUARD + BIT * l;
    trailEnd = dataEnd + GUARD;
    st = 1'b0; ce = 1'b0; bz = 1'b0; dn = 1'b0; idx = '0;
    k = 0; c = 0;
    if (t >= 1 && t <= trailEnd) begin
      bz = 1'b1;
      ce = 1'b1;
      st = (((t - 1) % SDIV) == 0);
    end
    if (t > GUARD && t <= dataEnd) begin
      k   = (t - GUARD - 1) / BIT;
      c   = (t - GUARD - 1) % BIT;
      idx = 7'(k);
      if (d[k]) ce = !((c >= BIT / 2) && (c < BIT / 2 + PAUSE));
      else      ce = (c >= PAUSE);
    end
    if (t == trailEnd + 1) dn = 1'b1;
    return {st, ce, bz, dn, idx};
  endfunction

  // Full burst, checked every cycle through the IDLE cycle after DONE.
  // With disturb set, start/data/len are scrambled during the burst.
  task automatic runBurst(input string tag, input logic [63:0] d,
                          input logic [6:0] lenIn, input int l, input bit disturb);
    int doneT;
    logic prevCe;
    doneT = 2 * GUARD + BIT * l + 1;
    busyC = 0; offC = 0; stepC = 0; pauseC = 0; stepInPause = 0;
    prevCe = 1'b1;
    applyStimulus(1'b1, 1'b0, d, lenIn);
    for (int t = 1; t <= doneT + 1; t++) begin
      tick();
      checkOutput($sformatf("%s t=%0d", tag, t), 32'(outVec()),
                  32'(expectedVec(t, d, l)));
      if (busy_out) busyC++;
      if (step_out) stepC++;
      if (busy_out && !carrier_en_out) begin
        offC++;
        if (step_out) stepInPause++;
        if (prevCe) pauseC++;
      end
      prevCe = carrier_en_out;
      if (disturb && t < doneT - 2) applyStimulus(1'b1, 1'b0, ~d, 7'd64);
      else                          applyStimulus(1'b0, 1'b0, d, 7'd0);
    end
  endtask

  initial begin
    // Reset asserted: everything must be zero.
    #2 rst_in = 1'b0;
    #1 checkOutput("reset async", 32'(outVec()), 32'(IDLE_VEC));
    tick();
    checkOutput("reset held", 32'(outVec()), 32'(IDLE_VEC));
    #3 rst_in = 1'b1;
    tick();
    checkOutput("idle after reset", 32'(outVec()), 32'(IDLE_VEC));

    // data=0b10, len=2, with start/data/len disturbed mid-burst.
    runBurst("b2", 64'h2, 7'd2, 2, 1'b1);
    checkOutput("b2 busy cycles", 32'(busyC), 32'd48);
    checkOutput("b2 off cycles", 32'(offC), 32'd8);
    checkOutput("b2 pauses", 32'(pauseC), 32'd2);
    checkOutput("b2 steps", 32'(stepC), 32'd24);

    // len=0: guard carrier only.
    runBurst("b0", 64'hDEAD_BEEF, 7'd0, 0, 1'b0);
    checkOutput("b0 busy cycles", 32'(busyC), 32'd16);
    checkOutput("b0 off cycles", 32'(offC), 32'd0);

    // len=100 clamps to 64, all ones.
    runBurst("b64", '1, 7'd100, 64, 1'b0);
    checkOutput("b64 busy cycles", 32'(busyC), 32'd1040);
    checkOutput("b64 pauses", 32'(pauseC), 32'd64);
    checkOutput("b64 off cycles", 32'(offC), 32'd256);

    // len=1, bit '1': step pulses continue through the pause.
    runBurst("b1", 64'h1, 7'd1, 1, 1'b0);
    checkOutput("b1 steps", 32'(stepC), 32'd16);
    checkOutput("b1 steps in pause", 32'(stepInPause), 32'd2);

    // Abort at DATA bit 3, c=5, then immediate restart.
    applyStimulus(1'b1, 1'b0, 64'hA5, 7'd8);
    for (int t = 1; t <= 62; t++) begin
      tick();
      checkOutput($sformatf("ab t=%0d", t), 32'(outVec()),
                  32'(expectedVec(t, 64'hA5, 8)));
      applyStimulus(1'b0, 1'b0, 64'hA5, 7'd8);
    end
    checkOutput("ab bit idx", 32'(bit_idx_out), 32'd3);
    applyStimulus(1'b0, 1'b1, 64'hA5, 7'd8);
    tick();
    checkOutput("abort outputs", 32'(outVec()), 32'(IDLE_VEC));
    applyStimulus(1'b1, 1'b0, 64'h0, 7'd0);
    tick();
    checkOutput("restart after abort", 32'(outVec()), 32'(LEAD0_VEC));
    applyStimulus(1'b0, 1'b1, 64'h0, 7'd0);
    tick();
    checkOutput("abort in lead", 32'(outVec()), 32'(IDLE_VEC));

    // Abort and start together in IDLE: abort wins.
    applyStimulus(1'b1, 1'b1, 64'h3, 7'd2);
    tick();
    checkOutput("abort beats start", 32'(outVec()), 32'(IDLE_VEC));
    applyStimulus(1'b0, 1'b0, 64'h0, 7'd0);
    tick();
    checkOutput("still idle", 32'(outVec()), 32'(IDLE_VEC));

    // Start held high through DONE restarts after one IDLE cycle.
    applyStimulus(1'b1, 1'b0, 64'h0, 7'd0);
    for (int t = 1; t <= 18; t++) begin
      tick();
      checkOutput($sformatf("hold t=%0d", t), 32'(outVec()),
                  32'(expectedVec(t, 64'h0, 0)));
    end
    tick();
    checkOutput("hold restart", 32'(outVec()), 32'(LEAD0_VEC));
    applyStimulus(1'b0, 1'b1, 64'h0, 7'd0);
    tick();
    checkOutput("hold abort", 32'(outVec()), 32'(IDLE_VEC));

    // Asynchronous reset mid-LEAD, start during reset ignored.
    applyStimulus(1'b1, 1'b0, '1, 7'd5);
    tick();
    applyStimulus(1'b0, 1'b0, '1, 7'd5);
    tick();
    tick();
    checkOutput("pre-reset lead", 32'(outVec()), 32'(expectedVec(3, '1, 5)));
    #2 rst_in = 1'b0;
    applyStimulus(1'b1, 1'b0, '1, 7'd0);
    #1 checkOutput("mid-lead async reset", 32'(outVec()), 32'(IDLE_VEC));
    tick();
    checkOutput("reset start ignored", 32'(outVec()), 32'(IDLE_VEC));
    #3 rst_in = 1'b1;
    tick();
    checkOutput("first edge after reset", 32'(outVec()), 32'(LEAD0_VEC));
    applyStimulus(1'b0, 1'b1, 64'h0, 7'd0);
    tick();
    checkOutput("final abort", 32'(outVec()), 32'(IDLE_VEC));
    applyStimulus(1'b0, 1'b0, 64'h0, 7'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
